// File: rtl/csr_bus_master_pkg.sv
// ============================================================================
// Module      : csr_bus_master_pkg
// Description : Shared constants and FSM state encoding for the CSR bus
//               master and the slave-side register blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_bus_master_pkg;

    // CSR address width: [13:10] selects the slave, [9:0] the register
    localparam int CSR_AW = 14;
    // CSR data width (always full words)
    localparam int CSR_DW = 32;
    // Width of the read-latency counter (read_wait up to 7)
    localparam int WAIT_W = 3;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_READ_DONE = 3'd3,
        ST_GAP       = 3'd4
    } csr_state_t;

endpackage : csr_bus_master_pkg

`default_nettype wire

// File: rtl/csr_bus_master.sv
// ============================================================================
// Module      : csr_bus_master
// Description : Wishbone classic slave to CSR bus initiator. Serialises single
//               32-bit accesses, issues one-cycle CSR write strobes and times
//               the fixed-latency CSR read path before acking Wishbone.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_bus_master
    import csr_bus_master_pkg::*;
#(
    parameter int READ_WAIT = 1,   // cycles after the address cycle before csr_di is sampled (1..7)
    parameter int ADR_LSB   = 2    // Wishbone address bit mapped to csr_a[0]
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [CSR_DW-1:0] csr_do,
    input  logic [CSR_DW-1:0] csr_di
);

    localparam logic [WAIT_W-1:0] c_wait_init = WAIT_W'(READ_WAIT);

    csr_state_t        r_state;
    csr_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;
    logic              w_ack_nxt;
    logic              w_we_nxt;
    logic [31:0]       w_dat_nxt;
    logic [CSR_AW-1:0] w_a_nxt;
    logic [CSR_DW-1:0] w_do_nxt;

    // New request: the ack term keeps a just-acked strobe from re-triggering
    logic              w_req;
    logic [CSR_AW-1:0] w_adr;
    // Address bits outside the CSR window are decoded by the interconnect
    logic              w_unused_adr;

    assign w_req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign w_adr        = wb_adr_i[ADR_LSB + CSR_AW - 1 : ADR_LSB];
    assign w_unused_adr = ^wb_adr_i;

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_dat_nxt   = wb_dat_o;
        w_a_nxt     = csr_a;
        w_do_nxt    = csr_do;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_a_nxt  = w_adr;
                    w_do_nxt = wb_dat_i;
                    w_we_nxt = wb_we_i;
                    if (wb_we_i) begin
                        // Write strobe and ack share the same cycle
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_cnt_nxt   = c_wait_init;
                        w_state_nxt = ST_READ_WAIT;
                    end
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_GAP;
            end
            ST_READ_WAIT: begin
                if (!wb_cyc_i) begin
                    // Master gave up: no ack, read data left untouched
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_dat_nxt   = csr_di;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_READ_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_READ_DONE: begin
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            csr_a    <= '0;
            csr_we   <= 1'b0;
            csr_do   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            wb_ack_o <= w_ack_nxt;
            wb_dat_o <= w_dat_nxt;
            csr_a    <= w_a_nxt;
            csr_we   <= w_we_nxt;
            csr_do   <= w_do_nxt;
        end
    end

endmodule : csr_bus_master

`default_nettype wire

// File: tb/tb_csr_bus_master.sv
// ============================================================================
// Module      : tb_csr_bus_master
// Description : Self-checking bench for csr_bus_master. Two instances
//               (read_wait = 1 and 3) each with a registered CSR slave model.
//               A transaction-level model predicts per-cycle ack/csr_we and
//               the held csr_a/csr_do/wb_dat_o values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_bus_master;
    import csr_bus_master_pkg::*;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr  [2];
    logic [31:0] dati [2];
    logic [31:0] dato [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic        ack  [2];
    logic [13:0] ca   [2];
    logic        cwe  [2];
    logic [31:0] cdo  [2];
    logic [31:0] cdi  [2];

    logic [31:0] smem    [2][64];
    logic [31:0] mdl_mem [2][64];

    bit          exp_ack [2][MAXC];
    bit          exp_we  [2][MAXC];
    bit          chg_a   [2][MAXC];
    logic [13:0] val_a   [2][MAXC];
    logic [31:0] val_do  [2][MAXC];
    bit          chg_d   [2][MAXC];
    logic [31:0] val_d   [2][MAXC];
    logic [13:0] mdl_a   [2];
    logic [31:0] mdl_do  [2];
    logic [31:0] mdl_dat [2];
    int          free_c  [2];
    int          last_ack[2];
    int          ack_cnt [2];

    int cycle  = 0;
    int passed = 0;
    int total  = 0;
    bit en     = 1'b0;

    always #5 clk = ~clk;

    csr_bus_master #(.READ_WAIT(1), .ADR_LSB(2)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .wb_adr_i(adr[0]), .wb_dat_i(dati[0]), .wb_dat_o(dato[0]),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_ack_o(ack[0]),
        .csr_a(ca[0]), .csr_we(cwe[0]), .csr_do(cdo[0]), .csr_di(cdi[0])
    );

    csr_bus_master #(.READ_WAIT(3), .ADR_LSB(2)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .wb_adr_i(adr[1]), .wb_dat_i(dati[1]), .wb_dat_o(dato[1]),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_ack_o(ack[1]),
        .csr_a(ca[1]), .csr_we(cwe[1]), .csr_do(cdo[1]), .csr_di(cdi[1])
    );

    function automatic int rw(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, act, exp);
        else
            passed++;
    endtask

    // Cycle counter: value during a cycle is the number of rising edges seen
    always @(posedge clk) cycle <= cycle + 1;

    // Registered CSR slave per instance: write on csr_we, read data one cycle later
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int i = 0; i < 64; i++)
                    smem[k][i] <= (i == 31) ? 32'hABADFACE : 32'h0;
                cdi[k] <= 32'h0;
            end else begin
                if (cwe[k]) smem[k][ca[k][5:0]] <= cdo[k];
                cdi[k] <= smem[k][ca[k][5:0]];
            end
        end
    end

    // Per-cycle comparison of both instances against the transaction model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ack[k] === 1'b1) begin
                last_ack[k] = cycle;
                ack_cnt[k]  = ack_cnt[k] + 1;
            end
            if (en && cycle < MAXC) begin
                if (chg_a[k][cycle]) begin
                    mdl_a[k]  = val_a[k][cycle];
                    mdl_do[k] = val_do[k][cycle];
                end
                if (chg_d[k][cycle]) mdl_dat[k] = val_d[k][cycle];
                chk($sformatf("ack%0d", k),    {31'b0, ack[k]}, {31'b0, exp_ack[k][cycle]});
                chk($sformatf("csr_we%0d", k), {31'b0, cwe[k]}, {31'b0, exp_we[k][cycle]});
                chk($sformatf("csr_a%0d", k),  {18'b0, ca[k]},  {18'b0, mdl_a[k]});
                chk($sformatf("csr_do%0d", k), cdo[k],  mdl_do[k]);
                chk($sformatf("dat_o%0d", k),  dato[k], mdl_dat[k]);
            end
        end
    end

    // Issue one Wishbone request on instance k and record its predicted effects.
    // Called just after a rising edge; returns just after the edge following
    // the ack cycle (or the cycle after the abort).
    task automatic req(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, input int abort_after);
        int c, acc, end_c;
        logic [13:0] am;
        c = cycle;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dati[k] = d;
        acc = (c > free_c[k]) ? c : free_c[k];
        am  = a[15:2];
        chg_a[k][acc+1]  = 1'b1;
        val_a[k][acc+1]  = am;
        val_do[k][acc+1] = d;
        if (w) begin
            exp_ack[k][acc+1] = 1'b1;
            exp_we[k][acc+1]  = 1'b1;
            mdl_mem[k][am[5:0]] = d;
            end_c = acc + 1;
            free_c[k] = acc + 3;
        end else if (abort_after >= 0) begin
            end_c = acc + 1 + abort_after;
            free_c[k] = end_c + 1;
        end else begin
            end_c = acc + 2 + rw(k);
            exp_ack[k][end_c] = 1'b1;
            chg_d[k][end_c]   = 1'b1;
            val_d[k][end_c]   = mdl_mem[k][am[5:0]];
            free_c[k] = end_c + 2;
        end
        if (!w && abort_after >= 0) begin
            repeat (end_c - c) begin @(posedge clk); #1; end
            cyc[k] = 1'b0;
            @(posedge clk); #1;
            stb[k] = 1'b0;
        end else begin
            repeat (end_c - c + 1) begin @(posedge clk); #1; end
            if (!hold) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
        end
    endtask

    initial begin
        int c0, n0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) mdl_mem[k][i] = (i == 31) ? 32'hABADFACE : 32'h0;
            mdl_a[k] = '0; mdl_do[k] = '0; mdl_dat[k] = '0;
            free_c[k] = 0; last_ack[k] = -1; ack_cnt[k] = 0;
            cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1;
            adr[k] = 32'h0000_0014; dati[k] = 32'h1111_1111;
        end
        rst_n = 1'b0;

        // Reset held with an active request: nothing may happen
        repeat (4) begin
            @(negedge clk);
            chk("rst_ack",    {31'b0, ack[0]}, 32'h0);
            chk("rst_csr_we", {31'b0, cwe[0]}, 32'h0);
            chk("rst_csr_a",  {18'b0, ca[0]},  32'h0);
        end
        chk("rst_dat_o", dato[1], 32'h0);

        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;

        // Write 0xDEADBEEF to register 5: ack in A+1
        c0 = cycle;
        req(0, 1'b1, 32'h0000_0014, 32'hDEADBEEF, 1'b0, -1);
        chk("wr_ack_cycle", last_ack[0], c0 + 1);
        chk("wr_csr_a", {18'b0, ca[0]}, 32'h0000_0005);
        chk("wr_csr_do", cdo[0], 32'hDEADBEEF);
        chk("wr_slave_reg5", smem[0][5], 32'hDEADBEEF);
        @(posedge clk); #1;

        // Read register 0x1F: ack in A+3 with the slave's data
        c0 = cycle;
        req(0, 1'b0, 32'h0000_007C, 32'h1234_5678, 1'b0, -1);
        chk("rd_ack_cycle", last_ack[0], c0 + 3);
        chk("rd_dat", dato[0], 32'hABADFACE);
        @(posedge clk); #1;

        // Back-to-back write then read with stb held high
        n0 = ack_cnt[0];
        req(0, 1'b1, 32'h0000_0020, 32'h0BADF00D, 1'b1, -1);
        req(0, 1'b0, 32'h0000_0020, 32'h5555_AAAA, 1'b0, -1);
        chk("b2b_ack_count", ack_cnt[0] - n0, 32'd2);
        chk("b2b_dat", dato[0], 32'h0BADF00D);
        @(posedge clk); #1;

        // Abort a read during READ_WAIT, then write straight away
        n0 = ack_cnt[0];
        req(0, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 0);
        chk("abort_no_ack", ack_cnt[0] - n0, 32'd0);
        chk("abort_dat_kept", dato[0], 32'h0BADF00D);
        c0 = cycle;
        req(0, 1'b1, 32'h0000_0030, 32'hCAFE_0001, 1'b0, -1);
        chk("post_abort_ack_cycle", last_ack[0], c0 + 1);
        @(posedge clk); #1;

        // Read back register 5 on the read_wait=1 instance
        req(0, 1'b0, 32'h0000_0014, 32'h0, 1'b0, -1);
        chk("rd5_dat", dato[0], 32'hDEADBEEF);

        // read_wait=3 instance: ack in A+5
        c0 = cycle;
        req(1, 1'b0, 32'h0000_007C, 32'h0, 1'b0, -1);
        chk("rw3_ack_cycle", last_ack[1], c0 + 5);
        chk("rw3_dat", dato[1], 32'hABADFACE);
        @(posedge clk); #1;
        req(1, 1'b1, 32'h0000_0104, 32'h600D_D00D, 1'b1, -1);
        req(1, 1'b0, 32'h0000_0104, 32'h0, 1'b0, -1);
        chk("rw3_wr_rd_dat", dato[1], 32'h600D_D00D);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_csr_bus_master

`default_nettype wire
